maxcut_seq: RTL and testbench

//  Sequential, parametrised max-cut decision block: "does partition part cut
//  at least cut edges of the compile-time graph EDGE_LIST?". Scans one edge
//  per cycle and terminates early on accept or on a proven reject.

---
 rtl/maxcut_pkg.sv | 30 +++
 rtl/maxcut_edge_mux.sv | 42 ++++
 rtl/maxcut_seq.sv | 121 ++++++++++++
 tb/tb_maxcut_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/maxcut_pkg.sv
// Shared definitions for the sequential max-cut decision block:
// FSM state encoding, a constant-friendly clog2 and edge field extractors.
package maxcut_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    // Ceiling log2 usable in localparam expressions; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Low vertex of a packed {v,u} edge field.
    function automatic int edge_u(input logic [31:0] fld, input int vw);
        return int'(fld & ((32'd1 << vw) - 32'd1));
    endfunction

    // High vertex of a packed {v,u} edge field.
    function automatic int edge_v(input logic [31:0] fld, input int vw);
        return int'((fld >> vw) & ((32'd1 << vw) - 32'd1));
    endfunction

endpackage

// File: rtl/maxcut_edge_mux.sv
// Combinational edge selector: reports whether edge idx of the compile-time
// edge list crosses the latched partition.
module maxcut_edge_mux
    import maxcut_pkg::*;
#(
    parameter int N_VERTICES = 5,
    parameter int N_EDGES    = 6,
    parameter int VW         = 3,
    parameter int IW         = 3,
    parameter logic [2*VW*N_EDGES-1:0] EDGE_LIST =
        {6'o43, 6'o32, 6'o41, 6'o30, 6'o20, 6'o10}
) (
    input  logic [IW-1:0]         idx,
    input  logic [N_VERTICES-1:0] part_q,
    output logic                  e
);

    logic [N_EDGES-1:0] cut_bits;

    // One crossing flag per edge, endpoints resolved at elaboration.
    for (genvar gi = 0; gi < N_EDGES; gi++) begin : g_edge
        localparam int U = edge_u(32'(EDGE_LIST[2*VW*gi +: 2*VW]), VW);
        localparam int V = edge_v(32'(EDGE_LIST[2*VW*gi +: 2*VW]), VW);
        if (U >= N_VERTICES || V >= N_VERTICES) begin : g_bad
            $error("maxcut_edge_mux: edge %0d references a vertex >= N_VERTICES", gi);
            assign cut_bits[gi] = 1'b0;
        end else begin : g_ok
            assign cut_bits[gi] = part_q[U] != part_q[V];
        end
    end

    // Select the flag of the edge currently being scanned.
    always_comb begin
        e = 1'b0;
        for (int k = 0; k < N_EDGES; k++) begin
            if (idx == IW'(k)) begin
                e = cut_bits[k];
            end
        end
    end

endmodule

// File: rtl/maxcut_seq.sv
// Sequential max-cut decision: scans one edge per cycle and stops as soon as
// the threshold is reached or can no longer be reached.
module maxcut_seq
    import maxcut_pkg::*;
#(
    parameter int N_VERTICES = 5,
    parameter int N_EDGES    = 6,
    parameter int VW         = 3,
    parameter int BITS       = 3,
    parameter logic [2*VW*N_EDGES-1:0] EDGE_LIST =
        {6'o43, 6'o32, 6'o41, 6'o30, 6'o20, 6'o10}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [N_VERTICES-1:0] part,
    input  logic [BITS-1:0]       cut,
    output logic                  busy,
    output logic                  done,
    output logic                  valid,
    output logic [BITS-1:0]       cut_size
);

    localparam int IW = (N_EDGES > 1) ? clog2(N_EDGES) : 1;

    state_t                state_reg, state_next;
    logic [N_VERTICES-1:0] part_reg;
    logic [BITS-1:0]       cut_reg;
    logic [IW-1:0]         idx_reg;
    logic [BITS-1:0]       count_reg;
    logic                  e;
    logic [BITS:0]         cnt_next;
    logic [BITS:0]         rem;
    logic                  accept;
    logic                  reject;
    logic                  load;
    logic                  finish;

    maxcut_edge_mux #(
        .N_VERTICES (N_VERTICES),
        .N_EDGES    (N_EDGES),
        .VW         (VW),
        .IW         (IW),
        .EDGE_LIST  (EDGE_LIST)
    ) u_edge_mux (
        .idx    (idx_reg),
        .part_q (part_reg),
        .e      (e)
    );

    // Running count and the best case still reachable, in one extra bit.
    always_comb begin
        cnt_next = {1'b0, count_reg} + {{BITS{1'b0}}, e};
        rem      = (BITS+1)'(N_EDGES - 1) - {{(BITS+1-IW){1'b0}}, idx_reg};
        accept   = cnt_next >= {1'b0, cut_reg};
        reject   = (cnt_next + rem) < {1'b0, cut_reg};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state plus load/finish strobes; accept takes priority over reject.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                if (accept || reject) begin
                    finish     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Operand latches, scan counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            part_reg  <= '0;
            cut_reg   <= '0;
            idx_reg   <= '0;
            count_reg <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            valid     <= 1'b0;
            cut_size  <= '0;
        end else begin
            done <= finish;
            if (load) begin
                part_reg  <= part;
                cut_reg   <= cut;
                idx_reg   <= '0;
                count_reg <= '0;
                busy      <= 1'b1;
                valid     <= 1'b0;
            end else if (finish) begin
                cut_size <= cnt_next[BITS-1:0];
                valid    <= accept;
                busy     <= 1'b0;
            end else if (state_reg == S_SCAN) begin
                count_reg <= cnt_next[BITS-1:0];
                idx_reg   <= idx_reg + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_maxcut_seq.sv
// Scoreboard bench for maxcut_seq: stimulus pushes reference results, a
// negedge monitor pops and compares them whenever done pulses.
module tb_maxcut_seq;

    localparam int NV = 5;
    localparam int NE = 6;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [NV-1:0] part;
    logic [2:0]    cut;
    logic          busy;
    logic          done;
    logic          valid;
    logic [2:0]    cut_size;

    typedef struct {
        int v;
        int cs;
        int t;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_checks;
    int   n_pass;
    int   done_cnt;

    // Edge endpoints written out by hand, independent of the packed list.
    int eu[NE] = '{0, 0, 0, 1, 2, 3};
    int ev[NE] = '{1, 2, 3, 4, 3, 4};

    maxcut_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .part     (part),
        .cut      (cut),
        .busy     (busy),
        .done     (done),
        .valid    (valid),
        .cut_size (cut_size)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: walk edges counting cut and uncut ones; accept once enough
    // are cut, reject once more than N_EDGES-cut edges are known to be uncut.
    function automatic exp_t ref_eval(input logic [NV-1:0] p, input int c);
        exp_t r;
        int   cuts;
        int   uncut;
        cuts  = 0;
        uncut = 0;
        r     = '{v: 0, cs: 0, t: 0, lat: 0};
        for (int k = 0; k < NE; k++) begin
            if (p[eu[k]] != p[ev[k]]) cuts++;
            else uncut++;
            if (cuts >= c) begin
                r.v = 1; r.cs = cuts; r.lat = k + 2;
                return r;
            end
            if (uncut > NE - c) begin
                r.v = 0; r.cs = cuts; r.lat = k + 2;
                return r;
            end
        end
        return r;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t x;
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                x = sb.pop_front();
                $display("txn t=%0d: valid=%0d cut_size=%0d latency=%0d (exp %0d/%0d/%0d)",
                         x.t, valid, cut_size, cyc - x.t, x.v, x.cs, x.lat);
                chk("valid", int'(valid), x.v);
                chk("cut_size", int'(cut_size), x.cs);
                chk("latency", cyc - x.t, x.lat);
            end
        end
    end

    // Wait for an idle slot, pulse start, then scramble the inputs.
    task automatic run(input logic [NV-1:0] p, input int c);
        exp_t x;
        int   w;
        w = 0;
        @(negedge clk);
        while (busy && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (busy) chk("idle_timeout", 1, 0);
        x     = ref_eval(p, c);
        x.t   = cyc;
        sb.push_back(x);
        start = 1'b1;
        part  = p;
        cut   = 3'(c);
        @(negedge clk);
        start = 1'b0;
        part  = NV'($urandom);
        cut   = 3'($urandom);
        chk("busy_after_start", int'(busy), 1);
        chk("valid_cleared", int'(valid), 0);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        done_cnt = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        part     = '0;
        cut      = '0;
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_cut_size", int'(cut_size), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases: last-edge accept, mid reject, early accept,
        // full-length reject, zero threshold, threshold above edge count.
        run(5'b01110, 5);
        run(5'b01110, 6);
        run(5'b00001, 2);
        run(5'b00000, 1);
        run(5'b01110, 0);
        run(5'b10101, 7);
        drain();

        // Start re-pulsed while busy must be ignored.
        run(5'b01110, 5);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        part  = 5'b00000;
        cut   = 3'd0;
        @(negedge clk);
        start = 1'b0;
        drain();

        // Back-to-back runs land their start on the previous done cycle.
        run(5'b00001, 2);
        run(5'b01110, 0);
        run(5'b11010, 3);
        drain();

        // Asynchronous reset in the middle of a scan.
        run(5'b00000, 1);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_valid", int'(valid), 0);
        chk("midrst_cut_size", int'(cut_size), 0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        done_cnt = 0;
        repeat (12) @(negedge clk);
        chk("no_done_after_reset", done_cnt, 0);

        // Randomized partitions and thresholds.
        for (int i = 0; i < 40; i++) begin
            run(NV'($urandom), int'($urandom_range(0, 7)));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
